// File: rtl/instr_sequencer.sv
// Program sequencer: fetches 16-bit words from a 1-cycle-latency
// instruction store, runs jumps/loops, issues EXEC via valid/ready.
// Ports: clk, rst (sync, active-high), start, counter (fetch address),
// instructCode (read data), cmd_valid/cmd_ready/cmd_op (command),
// busy, done (1-cycle pulse), err (sticky until start/rst).
module instr_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int LOOP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [15:0]           counter,
  input  logic [DATA_WIDTH-1:0] instructCode,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [11:0]           cmd_op,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pc_q, pc_d;
  logic [LOOP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [11:0]           cmd_op_q, cmd_op_d;
  logic                  err_q, err_d;

  logic [3:0]  op;
  logic [11:0] arg;
  logic        inc_ok;
  logic        tgt_ok;

  assign op     = instructCode[15:12];
  assign arg    = instructCode[11:0];
  // Incrementing past the last word or jumping beyond the store
  // is fatal: the program ends with err instead of fetching.
  assign inc_ok = (32'(pc_q) != DEPTH - 1);
  assign tgt_ok = (32'(arg) < DEPTH);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    loop_cnt_d  = loop_cnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          4'h0, 4'h3: begin
            if (op == 4'h3) loop_cnt_d = arg[LOOP_WIDTH-1:0];
            if (inc_ok) begin
              pc_d    = pc_q + 1'b1;
              state_d = FETCH;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
          4'h1: begin
            cmd_op_d    = arg;
            cmd_valid_d = 1'b1;
            state_d     = ISSUE;
          end
          4'h2: begin
            if (tgt_ok) begin
              pc_d    = arg[PW-1:0];
              state_d = FETCH;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
          4'h4: begin
            if (loop_cnt_q != '0) begin
              if (tgt_ok) begin
                loop_cnt_d = loop_cnt_q - 1'b1;
                pc_d       = arg[PW-1:0];
                state_d    = FETCH;
              end else begin
                err_d   = 1'b1;
                state_d = DONE;
              end
            end else if (inc_ok) begin
              pc_d    = pc_q + 1'b1;
              state_d = FETCH;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
          4'hF: state_d = DONE;
          default: begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        endcase
      end
      ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (inc_ok) begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      loop_cnt_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      loop_cnt_q  <= loop_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      err_q       <= err_d;
    end
  end

  assign counter   = {{(16-PW){1'b0}}, pc_q};
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign err       = err_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE) && (state_q != DONE);

endmodule
